// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings for the hazard / forwarding control slice
//
// Purpose : operand-mux select codes, FSM state encoding and the hard-wired
//           zero register used by hazard_forward_ctrl and fwd_match.
// Ports   : none (package).
package hazard_pkg;

  // EX-stage operand mux select codes
  localparam logic [1:0] FWD_REGFILE = 2'd0;
  localparam logic [1:0] FWD_EXMEM   = 2'd1;
  localparam logic [1:0] FWD_MEMWB   = 2'd2;
  localparam logic [1:0] FWD_WBBYP   = 2'd3;

  // Load-use stall sequencer states
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  // Register specifier that is never written and therefore never forwarded
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/fwd_match.sv
// rtl/fwd_match.sv - priority comparator for one EX-stage operand
//
// Purpose : compares one decode-stage source register against the EX, MEM and
//           WB destinations and returns the forwarding select (nearest producer
//           wins) plus a flag saying the operand depends on a load now in EX.
// Ports   : src/use_src             decode source register and its use flag
//           ex_*, mem_*, wb_*       producer destinations and write enables
//           sel                     2-bit operand select (hazard_pkg FWD_*)
//           load_match              operand needs the result of the EX load
module fwd_match
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  use_src,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  output logic [1:0]            sel,
  output logic                  load_match
);

  logic src_live;

  // An unused operand or the zero register never forwards; this also covers
  // the "destination != 0" condition because src == rd is then required.
  assign src_live = use_src && (src != REG_ADDR_W'(REG_ZERO));

  always_comb begin
    sel = FWD_REGFILE;
    if (src_live) begin
      if (ex_reg_write && (ex_rd == src)) begin
        sel = FWD_EXMEM;
      end else if (mem_reg_write && (mem_rd == src)) begin
        sel = FWD_MEMWB;
      end else if (wb_reg_write && (wb_rd == src)) begin
        sel = FWD_WBBYP;
      end
    end
  end

  assign load_match = src_live && ex_mem_read && (ex_rd == src);

endmodule

// File: rtl/hazard_forward_ctrl.sv
// rtl/hazard_forward_ctrl.sv - EX operand forwarding selects and load-use stall control
//
// Purpose : registers the operand-A/B mux selects so they line up with the
//           instruction entering EX, and holds PC / IF-ID while inserting
//           LOAD_STALL_CYCLES bubbles into ID/EX on a load-use hazard.
// Ports   : Clk, Rst (async, active high), ext_stall (global freeze)
//           id_rs/id_rt, id_use_rs/id_use_rt   decode-stage sources
//           ex_rd, ex_reg_write, ex_mem_read   EX producer
//           mem_rd, mem_reg_write              MEM producer
//           wb_rd, wb_reg_write                WB producer
//           fwd_sel_a, fwd_sel_b               registered operand selects
//           pc_write_en, ifid_write_en, idex_flush   stall controls
// Config  : HAZARD_PERF_CNT_EN adds stall_count (out, 32) and
//           stall_count_clr (in) - a count of cycles that inserted a bubble.
module hazard_forward_ctrl
  import hazard_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int REG_ADDR_W        = 5
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  ext_stall,
`ifdef HAZARD_PERF_CNT_EN
  input  logic                  stall_count_clr,
  output logic [31:0]           stall_count,
`endif
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  output logic [1:0]            fwd_sel_a,
  output logic [1:0]            fwd_sel_b,
  output logic                  pc_write_en,
  output logic                  ifid_write_en,
  output logic                  idex_flush
);

  // Extra bubbles after the one raised combinationally in the hazard cycle
  localparam logic [2:0] STALL_INIT = 3'(LOAD_STALL_CYCLES - 1);

  state_t     state;
  logic [2:0] cnt;
  logic [1:0] sel_a, sel_b;
  logic       load_a, load_b;
  logic       hazard, stall_now;

  fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_a (
    .src           (id_rs),
    .use_src       (id_use_rs),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (sel_a),
    .load_match    (load_a)
  );

  fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_b (
    .src           (id_rt),
    .use_src       (id_use_rt),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (sel_b),
    .load_match    (load_b)
  );

  // Both operands hitting the same load still form a single stall sequence,
  // and nothing new is detected while a sequence is already running.
  assign hazard    = (state == ST_RUN) && (load_a || load_b);
  assign stall_now = hazard || (state == ST_STALL);

  always_comb begin
    pc_write_en   = 1'b1;
    ifid_write_en = 1'b1;
    idex_flush    = 1'b0;
    if (Rst) begin
      // released immediately, even when reset lands mid-stall
      pc_write_en   = 1'b1;
    end else if (ext_stall) begin
      // freeze: nothing advances and no bubble is injected
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      idex_flush    = 1'b0;
    end else if (stall_now) begin
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      idex_flush    = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      fwd_sel_a <= FWD_REGFILE;
      fwd_sel_b <= FWD_REGFILE;
      state     <= ST_RUN;
      cnt       <= 3'd0;
    end else if (!ext_stall) begin
      // a bubble entering EX carries no forwarding
      fwd_sel_a <= stall_now ? FWD_REGFILE : sel_a;
      fwd_sel_b <= stall_now ? FWD_REGFILE : sel_b;
      case (state)
        ST_RUN: begin
          if (hazard && (LOAD_STALL_CYCLES > 1)) begin
            state <= ST_STALL;
            cnt   <= STALL_INIT;
          end
        end
        ST_STALL: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            state <= ST_RUN;
          end
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Counts bubbles actually inserted; a frozen cycle inserts none.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      stall_count <= 32'd0;
    end else if (stall_count_clr) begin
      stall_count <= 32'd0;
    end else if (stall_now && !ext_stall) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb/tb_hazard_forward_ctrl.sv - self-checking bench for hazard_forward_ctrl
//
// Purpose : drives two instances (LOAD_STALL_CYCLES = 1 and 3) with directed
//           and random pipeline traffic and compares them to a bubble-count
//           reference model. HAZARD_PERF_CNT_EN also checks stall_count.
// Ports   : none.
module tb_hazard_forward_ctrl;

  logic       Clk;
  logic       rst;
  logic       ext_stall;
  logic       stall_count_clr;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
  logic       id_use_rs, id_use_rt;
  logic       ex_reg_write, ex_mem_read, mem_reg_write, wb_reg_write;

  logic [1:0]  fsa [2];
  logic [1:0]  fsb [2];
  logic [1:0]  pc_we, ifid_we, flush;
  logic [31:0] sc [2];

  int          n_cmp = 0;
  int          n_err = 0;
  int          lsc [2] = '{1, 3};
  int          left [2];
  logic [1:0]  m_sa [2];
  logic [1:0]  m_sb [2];
  logic [31:0] m_cnt [2];
  int          flush_seen [2];

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  hazard_forward_ctrl #(.LOAD_STALL_CYCLES(1), .REG_ADDR_W(5)) u_dut1 (
    .Clk (Clk), .Rst (rst), .ext_stall (ext_stall),
`ifdef HAZARD_PERF_CNT_EN
    .stall_count_clr (stall_count_clr), .stall_count (sc[0]),
`endif
    .id_rs (id_rs), .id_rt (id_rt), .id_use_rs (id_use_rs), .id_use_rt (id_use_rt),
    .ex_rd (ex_rd), .ex_reg_write (ex_reg_write), .ex_mem_read (ex_mem_read),
    .mem_rd (mem_rd), .mem_reg_write (mem_reg_write),
    .wb_rd (wb_rd), .wb_reg_write (wb_reg_write),
    .fwd_sel_a (fsa[0]), .fwd_sel_b (fsb[0]),
    .pc_write_en (pc_we[0]), .ifid_write_en (ifid_we[0]), .idex_flush (flush[0])
  );

  hazard_forward_ctrl #(.LOAD_STALL_CYCLES(3), .REG_ADDR_W(5)) u_dut3 (
    .Clk (Clk), .Rst (rst), .ext_stall (ext_stall),
`ifdef HAZARD_PERF_CNT_EN
    .stall_count_clr (stall_count_clr), .stall_count (sc[1]),
`endif
    .id_rs (id_rs), .id_rt (id_rt), .id_use_rs (id_use_rs), .id_use_rt (id_use_rt),
    .ex_rd (ex_rd), .ex_reg_write (ex_reg_write), .ex_mem_read (ex_mem_read),
    .mem_rd (mem_rd), .mem_reg_write (mem_reg_write),
    .wb_rd (wb_rd), .wb_reg_write (wb_reg_write),
    .fwd_sel_a (fsa[1]), .fwd_sel_b (fsb[1]),
    .pc_write_en (pc_we[1]), .ifid_write_en (ifid_we[1]), .idex_flush (flush[1])
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Nearest producer wins; register 0 and unused operands read the file.
  function automatic logic [1:0] ref_sel(input logic [4:0] x, input logic use_x);
    if (!use_x || x == 5'd0) return 2'd0;
    if (ex_reg_write && ex_rd == x) return 2'd1;
    if (mem_reg_write && mem_rd == x) return 2'd2;
    if (wb_reg_write && wb_rd == x) return 2'd3;
    return 2'd0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      left[k]  = 0;
      m_sa[k]  = 2'd0;
      m_sb[k]  = 2'd0;
      m_cnt[k] = 32'd0;
    end
  endtask

  task automatic clear_inputs();
    ext_stall = 0; stall_count_clr = 0;
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0;
    mem_rd = 0; mem_reg_write = 0; wb_rd = 0; wb_reg_write = 0;
  endtask

  // One clock: check stall controls mid-cycle, then the registered selects
  // just after the edge. Inputs must already be applied.
  task automatic step();
    logic       hz [2];
    logic       sn [2];
    logic [1:0] pa, pb;
    logic       lm;
    @(negedge Clk);
    pa = ref_sel(id_rs, id_use_rs);
    pb = ref_sel(id_rt, id_use_rt);
    lm = ex_mem_read && ex_rd != 0 &&
         ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
    for (int k = 0; k < 2; k++) begin
      hz[k] = (left[k] == 0) && lm;
      sn[k] = hz[k] || (left[k] > 0);
      check_val($sformatf("pc_write_en[%0d]", k), 32'(pc_we[k]),
                32'(rst ? 1'b1 : (ext_stall ? 1'b0 : !sn[k])));
      check_val($sformatf("ifid_write_en[%0d]", k), 32'(ifid_we[k]),
                32'(rst ? 1'b1 : (ext_stall ? 1'b0 : !sn[k])));
      check_val($sformatf("idex_flush[%0d]", k), 32'(flush[k]),
                32'(!rst && !ext_stall && sn[k]));
      if (flush[k]) flush_seen[k]++;
    end
    @(posedge Clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        left[k] = 0; m_sa[k] = 0; m_sb[k] = 0; m_cnt[k] = 0;
      end else begin
        if (!ext_stall) begin
          m_sa[k] = sn[k] ? 2'd0 : pa;
          m_sb[k] = sn[k] ? 2'd0 : pb;
          if (left[k] > 0) left[k]--;
          else if (hz[k]) left[k] = lsc[k] - 1;
        end
        if (stall_count_clr) m_cnt[k] = 0;
        else if (sn[k] && !ext_stall) m_cnt[k]++;
      end
      check_val($sformatf("fwd_sel_a[%0d]", k), 32'(fsa[k]), 32'(m_sa[k]));
      check_val($sformatf("fwd_sel_b[%0d]", k), 32'(fsb[k]), 32'(m_sb[k]));
`ifdef HAZARD_PERF_CNT_EN
      check_val($sformatf("stall_count[%0d]", k), sc[k], m_cnt[k]);
`endif
    end
  endtask

  initial begin
    clear_inputs();
    model_reset();
    flush_seen = '{0, 0};
    rst = 1;
    step();
    step();
    check_val("reset_sel_a", 32'(fsa[1]), 32'd0);
    check_val("reset_pc_we", 32'(pc_we[1]), 32'd1);
    rst = 0;

    // EX forwarding to operand A
    clear_inputs();
    ex_reg_write = 1; ex_rd = 8; id_rs = 8; id_use_rs = 1;
    step();
    check_val("ex_fwd_sel_a", 32'(fsa[0]), 32'd1);

    // MEM beats WB for operand B
    clear_inputs();
    mem_reg_write = 1; mem_rd = 9; wb_reg_write = 1; wb_rd = 9; id_rt = 9; id_use_rt = 1;
    step();
    check_val("mem_over_wb_sel_b", 32'(fsb[0]), 32'd2);

    // register 0 never forwards
    clear_inputs();
    ex_reg_write = 1; ex_rd = 0; id_rs = 0; id_use_rs = 1;
    step();
    check_val("r0_sel_a", 32'(fsa[0]), 32'd0);

    // load-use with a single bubble
    clear_inputs();
    ex_reg_write = 1; ex_mem_read = 1; ex_rd = 10; id_rs = 10; id_use_rs = 1;
    step();
    check_val("load_bubble_sel_a", 32'(fsa[0]), 32'd0);
    clear_inputs();
    mem_reg_write = 1; mem_rd = 10; id_rs = 10; id_use_rs = 1;
    step();
    check_val("load_after_sel_a", 32'(fsa[0]), 32'd2);
    clear_inputs();
    repeat (4) step();

    // three-bubble load-use on both operands, ext_stall pulse mid-sequence
    stall_count_clr = 1;
    step();
    clear_inputs();
    flush_seen = '{0, 0};
    ex_reg_write = 1; ex_mem_read = 1; ex_rd = 12;
    id_rs = 12; id_rt = 12; id_use_rs = 1; id_use_rt = 1;
    step();
    ex_reg_write = 0; ex_mem_read = 0; ex_rd = 0;
    mem_reg_write = 1; mem_rd = 12;
    step();
    ext_stall = 1;
    repeat (2) step();
    ext_stall = 0;
    repeat (3) step();
    check_val("lsc3_flush_cycles", 32'(flush_seen[1]), 32'd3);
`ifdef HAZARD_PERF_CNT_EN
    check_val("perf_after_lsc3", sc[1], 32'd3);
    stall_count_clr = 1;
    step();
    check_val("perf_clear", sc[1], 32'd0);
    stall_count_clr = 0;
`endif

    // reset in the middle of a stall sequence
    clear_inputs();
    ex_reg_write = 1; ex_mem_read = 1; ex_rd = 5; id_rt = 5; id_use_rt = 1;
    step();
    clear_inputs();
    rst = 1;
    #1;
    model_reset();
    check_val("rst_mid_pc_we", 32'(pc_we[1]), 32'd1);
    check_val("rst_mid_flush", 32'(flush[1]), 32'd0);
    check_val("rst_mid_sel_b", 32'(fsb[1]), 32'd0);
    step();
    rst = 0;
    step();
    check_val("rst_mid_resume", 32'(pc_we[1]), 32'd1);

    // random traffic over a small register range to force collisions
    for (int i = 0; i < 3000; i++) begin
      rst             = ($urandom_range(0, 299) == 0);
      ext_stall       = ($urandom_range(0, 9) == 0);
      stall_count_clr = ($urandom_range(0, 49) == 0);
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
      ex_rd = 5'($urandom_range(0, 3)); ex_reg_write = 1'($urandom);
      ex_mem_read = ($urandom_range(0, 3) == 0);
      mem_rd = 5'($urandom_range(0, 3)); mem_reg_write = 1'($urandom);
      wb_rd = 5'($urandom_range(0, 3)); wb_reg_write = 1'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
